// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the ordered reset sequencer.
// Used by reset_seq_ctrl (optional feature macro: RST_SEQ_SW_RST_EN).
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_RESET,
    ST_HOLD,
    ST_REL,
    ST_DONE
  } rst_seq_state_t;

  localparam int MAX_CH = 16;

  function automatic int cnt_w(int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/reset_seq_ctrl_sync.sv
// Reset synchronizer: async assert, clk-aligned release after STAGES edges.
// Output o_rst_s is high once the reset has been released in the clk domain.
module rst_sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic i_rst_async,
  output logic o_rst_s
);

  (* ASYNC_REG = "TRUE" *)
  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // shift a one in from the bottom of the chain
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], 1'b1};
  end

  // chain clears at once when the async reset asserts
  always_ff @(posedge clk or negedge i_rst_async) begin
    if (!i_rst_async) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign o_rst_s = sync_q[STAGES-1];

endmodule

// File: rtl/reset_seq_ctrl.sv
// Ordered multi-channel reset release, ch0 first, HOLD_CYC cycles apart.
// Optional software restart request when RST_SEQ_SW_RST_EN is defined.
module reset_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int   STAGES   = 2,
  parameter int   NUM_CH   = 4,
  parameter int   HOLD_CYC = 8,
  parameter logic RST_POL  = 1'b0
) (
  input  logic              clk,
  input  logic              i_rst_async,
`ifdef RST_SEQ_SW_RST_EN
  input  logic              i_sw_rst_req,
`endif
  output logic [NUM_CH-1:0] o_rst_sync,
  output logic              o_seq_done
);

  localparam int CW = cnt_w(HOLD_CYC);
  localparam int IW = cnt_w(NUM_CH);

  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] CNT_RELOAD = CW'(HOLD_CYC - 1);
  localparam logic [IW-1:0] IDX_ONE    = IW'(1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_CH - 1);

  if (NUM_CH > MAX_CH) begin : g_num_ch_too_large
    $error("reset_seq_ctrl: NUM_CH exceeds MAX_CH");
  end

  rst_seq_state_t    state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [NUM_CH-1:0] rst_q, rst_d;
  logic              done_q, done_d;
  logic              rel_fire;
  logic              rst_s;
  logic              rst_ok;

  rst_sync_chain #(
    .STAGES (STAGES)
  ) u_sync (
    .clk         (clk),
    .i_rst_async (i_rst_async),
    .o_rst_s     (rst_s)
  );

`ifdef RST_SEQ_SW_RST_EN
  logic          sw_q, sw_d;
  logic          blk_q, blk_d;
  logic [CW-1:0] hcnt_q, hcnt_d;

  // request register plus minimum-hold blocker for the restart
  always_comb begin
    sw_d   = i_sw_rst_req;
    blk_d  = blk_q;
    hcnt_d = hcnt_q;
    if (sw_q && !blk_q) begin
      blk_d  = 1'b1;
      hcnt_d = CNT_RELOAD;
    end else if (blk_q) begin
      if (hcnt_q != '0) begin
        hcnt_d = hcnt_q - CNT_ONE;
      end else if (!i_sw_rst_req) begin
        blk_d = 1'b0;
      end
    end
  end

  // software request state, cleared by the async reset
  always_ff @(posedge clk or negedge i_rst_async) begin
    if (!i_rst_async) begin
      sw_q   <= 1'b0;
      blk_q  <= 1'b0;
      hcnt_q <= '0;
    end else begin
      sw_q   <= sw_d;
      blk_q  <= blk_d;
      hcnt_q <= hcnt_d;
    end
  end

  assign rst_ok = rst_s & ~blk_q;
`else
  assign rst_ok = rst_s;
`endif

  // sequencer next state, counter, channel index and output levels
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    rst_d    = rst_q;
    done_d   = done_q;
    rel_fire = 1'b0;
    unique case (state_q)
      ST_RESET: begin
        if (rst_ok) begin
          if (HOLD_CYC == 1) begin
            rel_fire = 1'b1;
          end else if (cnt_q <= CNT_ONE) begin
            state_d = ST_REL;
          end else begin
            state_d = ST_HOLD;
            cnt_d   = cnt_q - CNT_ONE;
          end
        end
      end
      ST_HOLD: begin
        if (cnt_q <= CNT_ONE) begin
          state_d = ST_REL;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_REL: begin
        rel_fire = 1'b1;
      end
      ST_DONE: begin
        done_d = 1'b1;
      end
      default: begin
        state_d = ST_RESET;
      end
    endcase
    if (rel_fire) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (idx_q == IW'(k)) begin
          rst_d[k] = ~RST_POL;
        end
      end
      idx_d = idx_q + IDX_ONE;
      cnt_d = CNT_RELOAD;
      if (idx_q == IDX_LAST) begin
        state_d = ST_DONE;
      end else if (HOLD_CYC == 1) begin
        state_d = ST_REL;
      end else begin
        state_d = ST_HOLD;
      end
    end
`ifdef RST_SEQ_SW_RST_EN
    if (sw_q) begin
      state_d = ST_RESET;
      cnt_d   = CNT_RELOAD;
      idx_d   = '0;
      rst_d   = {NUM_CH{RST_POL}};
      done_d  = 1'b0;
    end
`endif
  end

  // sequencer state and output flops, all cleared by the async reset
  always_ff @(posedge clk or negedge i_rst_async) begin
    if (!i_rst_async) begin
      state_q <= ST_RESET;
      cnt_q   <= CNT_RELOAD;
      idx_q   <= '0;
      rst_q   <= {NUM_CH{RST_POL}};
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_q   <= rst_d;
      done_q  <= done_d;
    end
  end

  assign o_rst_sync = rst_q;
  assign o_seq_done = done_q;

endmodule
